sbox_share_ctrl: RTL

//  Sequences and time-shares one 32-bit, 4-byte combinational SubBytes unit between
//  two requesters: the round datapath (128-bit state, processed one word per slot)
//  and the key schedule (single-word SubWord).

---
 rtl/aes_sbox_pkg.sv | 10 +
 rtl/sbox_slot_arb.sv | 42 ++++
 rtl/sbox_share_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/aes_sbox_pkg.sv
// Shared types for the time-shared S-box word unit: grant codes and data FSM states.
package aes_sbox_pkg;

    localparam int SB_WORD_W = 32;

    typedef enum logic [1:0] {GNT_NONE, GNT_DATA, GNT_KEY} gnt_e;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} dst_e;

endpackage

// File: rtl/sbox_slot_arb.sv
// Two-way S-box slot grant between the round datapath and the key schedule.
// Build option SBOX_KEY_PRIO_EN: key always wins on contention; otherwise round robin.
module sbox_slot_arb
    import aes_sbox_pkg::*;
(
`ifndef SBOX_KEY_PRIO_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic data_req,
    input  logic key_req,
    output gnt_e gnt
);

`ifdef SBOX_KEY_PRIO_EN
    always_comb begin
        gnt = GNT_NONE;
        if (key_req)       gnt = GNT_KEY;
        else if (data_req) gnt = GNT_DATA;
    end
`else
    // rr_last_q = 1 means the key schedule owned the most recent granted slot
    logic rr_last_q;
    logic rr_last_d;

    always_comb begin
        gnt       = GNT_NONE;
        rr_last_d = rr_last_q;
        if (key_req && data_req) gnt = rr_last_q ? GNT_DATA : GNT_KEY;
        else if (key_req)        gnt = GNT_KEY;
        else if (data_req)       gnt = GNT_DATA;
        if (gnt == GNT_KEY)      rr_last_d = 1'b1;
        else if (gnt == GNT_DATA) rr_last_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_last_q <= 1'b1;
        else        rr_last_q <= rr_last_d;
    end
`endif

endmodule

// File: rtl/sbox_share_ctrl.sv
// Time-shares one 32-bit SubBytes unit between a block datapath (word per slot) and key SubWord.
// Contention policy selected by SBOX_KEY_PRIO_EN (defined: key priority; undefined: round robin).
module sbox_share_ctrl
    import aes_sbox_pkg::*;
#(
    parameter int NWORDS = 4,
    localparam int DAT_W = SB_WORD_W * NWORDS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dat_in_valid,
    output logic                 dat_in_ready,
    input  logic [DAT_W-1:0]     dat_in,
    output logic                 dat_out_valid,
    input  logic                 dat_out_ready,
    output logic [DAT_W-1:0]     dat_out,
    input  logic                 key_req_valid,
    output logic                 key_req_ready,
    input  logic [SB_WORD_W-1:0] key_req_word,
    output logic                 key_rsp_valid,
    output logic [SB_WORD_W-1:0] key_rsp_word,
    output logic [SB_WORD_W-1:0] sb_x,
    input  logic [SB_WORD_W-1:0] sb_y,
    output logic                 busy
);

    localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);

    dst_e                             st_q, st_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [NWORDS-1:0][SB_WORD_W-1:0] dat_q, dat_d;
    logic                             key_pend_q, key_pend_d;
    logic [SB_WORD_W-1:0]             key_q, key_d;
    logic                             key_rsp_valid_q, key_rsp_valid_d;
    logic [SB_WORD_W-1:0]             key_rsp_word_q, key_rsp_word_d;
    gnt_e                             gnt;

    sbox_slot_arb u_arb (
`ifndef SBOX_KEY_PRIO_EN
        .clk      (clk),
        .rst_n    (rst_n),
`endif
        .data_req (st_q == ST_RUN),
        .key_req  (key_pend_q),
        .gnt      (gnt)
    );

    always_comb begin
        st_d            = st_q;
        cnt_d           = cnt_q;
        dat_d           = dat_q;
        key_pend_d      = key_pend_q;
        key_d           = key_q;
        key_rsp_valid_d = 1'b0;
        key_rsp_word_d  = key_rsp_word_q;
        sb_x            = '0;

        case (gnt)
            GNT_DATA: sb_x = dat_q[cnt_q];
            GNT_KEY:  sb_x = key_q;
            default:  sb_x = '0;
        endcase

        // A pending key can only be served, never accepted, so these two never collide
        if (gnt == GNT_KEY) begin
            key_rsp_valid_d = 1'b1;
            key_rsp_word_d  = sb_y;
            key_pend_d      = 1'b0;
        end else if (key_req_valid && !key_pend_q) begin
            key_pend_d = 1'b1;
            key_d      = key_req_word;
        end

        case (st_q)
            ST_IDLE: if (dat_in_valid) begin
                dat_d = dat_in;
                cnt_d = '0;
                st_d  = ST_RUN;
            end
            ST_RUN: if (gnt == GNT_DATA) begin
                dat_d[cnt_q] = sb_y;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    st_d  = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: if (dat_out_ready) st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q            <= ST_IDLE;
            cnt_q           <= '0;
            dat_q           <= '0;
            key_pend_q      <= 1'b0;
            key_q           <= '0;
            key_rsp_valid_q <= 1'b0;
            key_rsp_word_q  <= '0;
        end else begin
            st_q            <= st_d;
            cnt_q           <= cnt_d;
            dat_q           <= dat_d;
            key_pend_q      <= key_pend_d;
            key_q           <= key_d;
            key_rsp_valid_q <= key_rsp_valid_d;
            key_rsp_word_q  <= key_rsp_word_d;
        end
    end

    assign dat_in_ready  = (st_q == ST_IDLE);
    assign dat_out_valid = (st_q == ST_HOLD);
    assign dat_out       = dat_q;
    assign key_req_ready = !key_pend_q;
    assign key_rsp_valid = key_rsp_valid_q;
    assign key_rsp_word  = key_rsp_word_q;
    assign busy          = (st_q != ST_IDLE) || key_pend_q;

endmodule
